softsign_divider: RTL

SOFTSIGN_DIVIDER -- requirements
Module: softsign_divider

---
 rtl/softsign_pkg.sv | 26 ++
 rtl/softsign_divider_div_step.sv | 28 ++
 rtl/softsign_divider.sv | 112 +++++++++++
 3 files changed

// File: rtl/softsign_pkg.sv
// Shared types and constants for the softsign fixed-point divider.
package softsign_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default number of quotient fraction bits.
  localparam int FRAC_BITS_DEFAULT = 30;

  // The remainder holds |X| (33 bits) plus one bit of headroom for the left shift.
  localparam int REM_W = 34;

  // Saturated magnitude for the default fraction width: 2^30 - 1.
  localparam logic [31:0] SAT_DEFAULT = 32'h3FFF_FFFF;

  // Saturated magnitude for an arbitrary fraction width: 2^frac_bits - 1.
  function automatic logic [31:0] sat_mag(input int frac_bits);
    logic [32:0] one_hot;
    one_hot = 33'd1 << frac_bits;
    return 32'(one_hot - 33'd1);
  endfunction

endpackage

// File: rtl/softsign_divider_div_step.sv
// One restoring-division step: shift, compare against the divisor, conditionally subtract.
module div_step
  import softsign_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic [31:0]      divisor,
  output logic [REM_W-1:0] rem_next,
  output logic             q_bit
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] divisor_ext;

  assign shifted     = {rem[REM_W-2:0], 1'b0};
  assign divisor_ext = {{(REM_W-32){1'b0}}, divisor};

  // Subtract when the shifted remainder covers the divisor; the quotient bit records it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rem_next = shifted;
    q_bit    = 1'b0;
    if (shifted >= divisor_ext) begin
      rem_next = shifted - divisor_ext;
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/softsign_divider.sv
// Signed-numerator / unsigned-denominator fixed-point divider for the softsign path.
// Produces trunc(X * 2^FRAC_BITS / denom), saturating when the magnitude would reach 1.0.
module softsign_divider
  import softsign_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] denom,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        div_err
);

  localparam int CNT_W = $clog2(FRAC_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAC_BITS);
  localparam logic [31:0] SAT = (FRAC_BITS == FRAC_BITS_DEFAULT) ? SAT_DEFAULT
                                                                  : sat_mag(FRAC_BITS);

  state_t               state;
  logic                 sign_q;
  logic                 err_q;
  logic [REM_W-1:0]     rem_q;
  logic [31:0]          divisor_q;
  logic [FRAC_BITS-1:0] quo_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [32:0]          abs_x;
  logic                 start_err;
  logic [REM_W-1:0]     rem_next;
  logic                 q_bit;
  logic [31:0]          mag;

  // Magnitude of X in 33 bits so that -2^31 becomes +2^31 without overflow.
  assign abs_x     = X[31] ? (33'd0 - {X[31], X}) : {1'b0, X};
  assign start_err = (denom == 32'd0) || (abs_x >= {1'b0, denom});

  div_step u_div_step (
    .rem      (rem_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Final magnitude before the sign is applied: saturated on error, else the quotient.
  assign mag = err_q ? SAT : {{(32-FRAC_BITS){1'b0}}, quo_q};

  // Control FSM with registered outputs; steps the division one bit per cycle.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      rem_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_q    <= X[31];
            err_q     <= start_err;
            rem_q     <= {1'b0, abs_x};
            divisor_q <= denom;
            quo_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state     <= DIV;
          end
        end

        DIV: begin
          if (cnt_q != LAST_STEP) begin
            rem_q <= rem_next;
            quo_q <= (quo_q << 1) | FRAC_BITS'(q_bit);
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // All steps taken: publish the signed result together with done.
            result  <= sign_q ? (32'd0 - mag) : mag;
            div_err <= err_q;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
